// File: rtl/spi_master.sv
// spi_master: mode-0 (CPOL=0, CPHA=0) SPI initiator.
// A word accepted on tx_valid/tx_ready is shifted out on spi_mosi while
// the reply is captured from spi_miso. The received word is delivered with
// a single-cycle rx_valid pulse. Every spi_clk phase lasts CLK_DIV cycles
// of clk_sys: lead setup, DATA_WIDTH high/low bit cells, trail hold, and a
// minimum deselect gap.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  spi_clk,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]            r_state;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_spi_clk;
  logic                  r_cs_n;
  logic                  r_mosi;

  logic                  w_idle;
  logic                  w_tick;
  logic                  w_last_bit;
  logic                  w_accept;
  logic                  w_first_bit;
  logic                  w_next_bit;
  logic [DATA_WIDTH-1:0] w_tx_next;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_idle     = (r_state == S_IDLE);
  assign w_tick     = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign w_accept   = tx_valid && w_idle;

  // Shift direction is fixed at elaboration; the wire order of outgoing
  // and incoming bits is the same so loopback returns the word unchanged.
  assign w_tx_next   = MSB_FIRST ? {r_tx_sh[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, r_tx_sh[DATA_WIDTH-1:1]};
  assign w_first_bit = MSB_FIRST ? tx_data[DATA_WIDTH-1] : tx_data[0];
  assign w_next_bit  = MSB_FIRST ? w_tx_next[DATA_WIDTH-1] : w_tx_next[0];
  assign w_rx_next   = MSB_FIRST ? {r_rx_sh[DATA_WIDTH-2:0], spi_miso}
                                 : {spi_miso, r_rx_sh[DATA_WIDTH-1:1]};

  // Half-period counter: every non-idle state leaves on its tick, so
  // clearing on the tick is the same as clearing on every state entry.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register in the design samples the pre-edge values of the others.
      r_div_cnt <= '0;
    end else if (w_idle || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Frame sequencer and shift datapath.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_spi_clk  <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx_sh   <= tx_data;
            r_rx_sh   <= '0;
            r_bit_cnt <= '0;
            r_cs_n    <= 1'b0;
            r_mosi    <= w_first_bit;
            r_state   <= S_LEAD;
          end
        end
        S_LEAD, S_LOW: begin
          if (w_tick) begin
            r_spi_clk <= 1'b1;
            r_rx_sh   <= w_rx_next;
            r_state   <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_tick) begin
            r_spi_clk <= 1'b0;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (w_last_bit) begin
              r_state <= S_TRAIL;
            end else begin
              r_tx_sh <= w_tx_next;
              r_mosi  <= w_next_bit;
              r_state <= S_LOW;
            end
          end
        end
        S_TRAIL: begin
          if (w_tick) begin
            r_cs_n     <= 1'b1;
            r_rx_data  <= r_rx_sh;
            r_rx_valid <= 1'b1;
            r_state    <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_tick) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready = w_idle;
  assign busy     = !w_idle;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign spi_clk  = r_spi_clk;
  assign spi_cs_n = r_cs_n;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: three spi_master instances (8b/div2 MSB-first, 8b/div2
// LSB-first, 16b/div5 MSB-first). A wire monitor measures each frame
// (edge spacing, cs_n low time, rising-edge count, mosi bit order) and the
// received word is compared against what the far end was made to send.
module tb_spi_master;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic rst_n = 1'b0;

  logic [7:0]  tx_data0 = '0, tx_data1 = '0;
  logic [15:0] tx_data2 = '0;
  logic        tx_valid0 = 1'b0, tx_valid1 = 1'b0, tx_valid2 = 1'b0;
  logic [7:0]  rx_data0, rx_data1;
  logic [15:0] rx_data2;
  logic        rx_valid0, rx_valid1, rx_valid2;
  logic        tx_ready0, tx_ready1, tx_ready2;
  logic        busy0, busy1, busy2;
  logic        spi_clk0, spi_clk1, spi_clk2;
  logic        cs_n0, cs_n1, cs_n2;
  logic        mosi0, mosi1, mosi2;
  logic        miso0, miso1, miso2;

  // Far end for instance 0: loopback, or a mode-0 slave that presents its
  // MSB at select and advances on each falling spi_clk.
  logic       lb0 = 1'b1;
  logic [7:0] slave_word = '0;
  logic [7:0] slave_sh = '0;
  logic       slave_prev_clk = 1'b0;

  assign miso0 = lb0 ? mosi0 : slave_sh[7];
  assign miso1 = mosi1;
  assign miso2 = mosi2;

  always @(negedge clk_sys) begin
    if (cs_n0) slave_sh <= slave_word;
    else if (slave_prev_clk && !spi_clk0) slave_sh <= {slave_sh[6:0], 1'b0};
    slave_prev_clk <= spi_clk0;
  end

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) u0 (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0),
    .spi_clk(spi_clk0), .spi_cs_n(cs_n0), .spi_mosi(mosi0), .spi_miso(miso0));

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b0)) u1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
    .spi_clk(spi_clk1), .spi_cs_n(cs_n1), .spi_mosi(mosi1), .spi_miso(miso1));

  spi_master #(.DATA_WIDTH(16), .CLK_DIV(5), .MSB_FIRST(1'b1)) u2 (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2),
    .spi_clk(spi_clk2), .spi_cs_n(cs_n2), .spi_mosi(mosi2), .spi_miso(miso2));

  // Uniform per-instance views for the monitor and tasks.
  logic        sclk_a[3], cs_a[3], mosi_a[3], rxv_a[3], ready_a[3], busy_a[3];
  logic [15:0] rxd_a[3];
  always_comb begin
    sclk_a[0] = spi_clk0; sclk_a[1] = spi_clk1; sclk_a[2] = spi_clk2;
    cs_a[0] = cs_n0; cs_a[1] = cs_n1; cs_a[2] = cs_n2;
    mosi_a[0] = mosi0; mosi_a[1] = mosi1; mosi_a[2] = mosi2;
    rxv_a[0] = rx_valid0; rxv_a[1] = rx_valid1; rxv_a[2] = rx_valid2;
    ready_a[0] = tx_ready0; ready_a[1] = tx_ready1; ready_a[2] = tx_ready2;
    busy_a[0] = busy0; busy_a[1] = busy1; busy_a[2] = busy2;
    rxd_a[0] = {8'h00, rx_data0}; rxd_a[1] = {8'h00, rx_data1}; rxd_a[2] = rx_data2;
  end

  function automatic int dw_of(int k); return (k == 2) ? 16 : 8; endfunction
  function automatic int cd_of(int k); return (k == 2) ? 5 : 2; endfunction
  function automatic bit msb_of(int k); return (k != 1); endfunction

  // Expected mosi bits in wire order: index i is the i-th bit on the wire.
  function automatic logic [15:0] wire_word(int k, logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < dw_of(k); i++)
      r[i] = msb_of(k) ? w[dw_of(k) - 1 - i] : w[i];
    return r;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Wire monitor state.
  bit          prev_clk[3] = '{0, 0, 0};
  bit          prev_cs[3] = '{1, 1, 1};
  bit          prev_mosi[3] = '{0, 0, 0};
  bit          prev_ready[3] = '{1, 1, 1};
  bit          in_frame[3] = '{0, 0, 0};
  int          since[3] = '{0, 0, 0};
  int          since_rxv[3] = '{0, 0, 0};
  int          low_cnt[3] = '{0, 0, 0};
  int          last_low[3] = '{0, 0, 0};
  int          high_cnt[3] = '{0, 0, 0};
  int          last_high[3] = '{0, 0, 0};
  int          rises[3] = '{0, 0, 0};
  int          last_rises[3] = '{0, 0, 0};
  int          rxv_cnt[3] = '{0, 0, 0};
  int          hp_bad[3] = '{0, 0, 0};
  int          mosi_bad[3] = '{0, 0, 0};
  int          hs_bad[3] = '{0, 0, 0};
  logic [15:0] bits[3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] last_bits[3] = '{16'h0, 16'h0, 16'h0};

  always @(negedge clk_sys) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        in_frame[k] = 0;
      end else begin
        bit rise, fall, csf, csr;
        rise = sclk_a[k] && !prev_clk[k];
        fall = !sclk_a[k] && prev_clk[k];
        csf  = !cs_a[k] && prev_cs[k];
        csr  = cs_a[k] && !prev_cs[k];
        since[k]++;
        since_rxv[k]++;
        if (busy_a[k] == ready_a[k]) hs_bad[k]++;
        if (rxv_a[k]) begin
          rxv_cnt[k]++;
          since_rxv[k] = 0;
          if (ready_a[k]) hs_bad[k]++;
        end
        if (ready_a[k] && !prev_ready[k] && since_rxv[k] != cd_of(k)) hs_bad[k]++;
        if (sclk_a[k] && cs_a[k]) hp_bad[k]++;
        if (mosi_a[k] != prev_mosi[k] && !fall && !csf) mosi_bad[k]++;
        if (csf) begin
          in_frame[k] = 1; since[k] = 0; low_cnt[k] = 0; rises[k] = 0; bits[k] = '0;
          last_high[k] = high_cnt[k];
        end
        if (csr) high_cnt[k] = 0;
        if (cs_a[k]) high_cnt[k]++;
        else low_cnt[k]++;
        if (in_frame[k] && (rise || fall || csr)) begin
          if (since[k] != cd_of(k)) hp_bad[k]++;
          since[k] = 0;
        end
        if (rise && in_frame[k]) begin
          if (rises[k] < 16) bits[k][rises[k]] = mosi_a[k];
          rises[k]++;
        end
        if (csr && in_frame[k]) begin
          last_low[k] = low_cnt[k]; last_rises[k] = rises[k]; last_bits[k] = bits[k];
          in_frame[k] = 0;
        end
      end
      prev_clk[k] = sclk_a[k]; prev_cs[k] = cs_a[k];
      prev_mosi[k] = mosi_a[k]; prev_ready[k] = ready_a[k];
    end
  end

  task automatic drive(int k, logic [15:0] d, logic v);
    case (k)
      0: begin tx_data0 = d[7:0]; tx_valid0 = v; end
      1: begin tx_data1 = d[7:0]; tx_valid1 = v; end
      default: begin tx_data2 = d; tx_valid2 = v; end
    endcase
  endtask

  task automatic wait_ready(int k, string tag);
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk_sys);
      if (ready_a[k]) ok = 1;
    end
    if (!ok) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_rxv(int k, string tag);
    bit ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk_sys);
      if (rxv_a[k]) ok = 1;
    end
    if (!ok) check({tag, "_rxv_timeout"}, 0, 1);
    repeat (2) @(negedge clk_sys);
  endtask

  // One complete frame on instance k with full wire-level checking.
  task automatic send(int k, logic [15:0] tx, bit lb, logic [7:0] sw,
                      logic [15:0] exp_rx, string tag);
    int n0;
    if (k == 0) begin lb0 = lb; slave_word = sw; end
    wait_ready(k, tag);
    n0 = rxv_cnt[k];
    drive(k, tx, 1'b1);
    @(negedge clk_sys);
    drive(k, ~tx, 1'b0);
    wait_rxv(k, tag);
    check({tag, "_rx_data"}, rxd_a[k], exp_rx);
    check({tag, "_rx_valid_pulses"}, rxv_cnt[k] - n0, 1);
    check({tag, "_cs_low_cycles"}, last_low[k], (2 * dw_of(k) + 1) * cd_of(k));
    check({tag, "_rising_edges"}, last_rises[k], dw_of(k));
    check({tag, "_mosi_bits"}, last_bits[k], wire_word(k, tx));
    check({tag, "_edge_spacing_errs"}, hp_bad[k], 0);
    check({tag, "_mosi_change_errs"}, mosi_bad[k], 0);
    check({tag, "_handshake_errs"}, hs_bad[k], 0);
  endtask

  typedef struct {
    logic [7:0] tx;
    bit         lb;
    logic [7:0] sw;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    bit ok;
    logic [15:0] r16;
    logic [7:0]  t8, s8;
    bit          l;

    vecs[0] = '{tx: 8'hA5, lb: 1'b1, sw: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hFF, lb: 1'b0, sw: 8'h3C, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h00, lb: 1'b1, sw: 8'hFF, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'h80, lb: 1'b0, sw: 8'h01, exp_rx: 8'h01};
    vecs[4] = '{tx: 8'h5A, lb: 1'b0, sw: 8'hC3, exp_rx: 8'hC3};

    // Reset values, during and after reset.
    repeat (3) @(negedge clk_sys);
    check("rst_cs_n", cs_n0, 1);
    check("rst_spi_clk", spi_clk0, 0);
    rst_n = 1'b1;
    @(negedge clk_sys);
    check("rst_tx_ready", tx_ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_mosi", mosi0, 0);
    check("rst_rx_valid", rx_valid0, 0);
    check("rst_rx_data", rx_data0, 0);

    // Directed vectors on the MSB-first 8-bit instance.
    for (int i = 0; i < 5; i++)
      send(0, {8'h00, vecs[i].tx}, vecs[i].lb, vecs[i].sw, {8'h00, vecs[i].exp_rx},
           $sformatf("vec%0d", i));

    // Randomized frames: the received word is whatever the far end sent.
    for (int i = 0; i < 8; i++) begin
      t8 = 8'($urandom_range(0, 255));
      s8 = 8'($urandom_range(0, 255));
      l  = 1'($urandom_range(0, 1));
      send(0, {8'h00, t8}, l, s8, l ? {8'h00, t8} : {8'h00, s8}, $sformatf("rnd%0d", i));
    end

    // LSB-first and wide/slow instances.
    send(1, 16'h0001, 1'b1, 8'h00, 16'h0001, "lsb_01");
    r16 = {8'h00, 8'($urandom_range(0, 255))};
    send(1, r16, 1'b1, 8'h00, r16, "lsb_rnd");
    send(2, 16'hBEEF, 1'b1, 8'h00, 16'hBEEF, "w16_beef");
    r16 = 16'($urandom_range(0, 65535));
    send(2, r16, 1'b1, 8'h00, r16, "w16_rnd");

    // Back-to-back with tx_valid held high; data changed mid-frame.
    lb0 = 1'b1;
    wait_ready(0, "b2b");
    n = rxv_cnt[0];
    drive(0, 16'h0011, 1'b1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk_sys); if (!tx_ready0) ok = 1; end
    check("b2b_first_accept", ok, 1);
    drive(0, 16'h0022, 1'b1);
    wait_rxv(0, "b2b_f1");
    check("b2b_rx_first", rx_data0, 8'h11);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk_sys); if (tx_ready0) ok = 1; end
    for (int i = 0; i < 20 && ok; i++) begin @(negedge clk_sys); if (!tx_ready0) ok = 0; end
    check("b2b_second_accept", ok, 0);
    drive(0, 16'h0000, 1'b0);
    wait_rxv(0, "b2b_f2");
    check("b2b_rx_second", rx_data0, 8'h22);
    check("b2b_pulses", rxv_cnt[0] - n, 2);
    check("b2b_cs_high_ge3", last_high[0] >= 3, 1);
    check("b2b_mosi_bits", last_bits[0], wire_word(0, 16'h0022));

    // Reset in the middle of a frame.
    wait_ready(0, "mid_rst");
    drive(0, 16'h0096, 1'b1);
    @(negedge clk_sys);
    drive(0, 16'h0000, 1'b0);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk_sys); if (rises[0] >= 4) ok = 1; end
    check("mid_rst_reached_bit4", ok, 1);
    check("mid_rst_cs_before", cs_n0, 0);
    n = rxv_cnt[0];
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", cs_n0, 1);
    check("mid_rst_spi_clk", spi_clk0, 0);
    check("mid_rst_tx_ready", tx_ready0, 1);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_rx_data", rx_data0, 0);
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_sys);
    check("mid_rst_no_rx_valid", rxv_cnt[0] - n, 0);
    send(0, 16'h005A, 1'b1, 8'h00, 16'h005A, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
